// File: rtl/lbuf_pkg.sv
// ============================================================================
// lbuf_pkg - shared FSM encodings and payload/page constants for lbuf_burst_gen
// Revision: 1.0
// ============================================================================
`default_nettype none

package lbuf_pkg;

  typedef enum logic [7:0] {
    IDLE     = 8'b0000_0001,
    CALC     = 8'b0000_0010,
    REQ      = 8'b0000_0100,
    WAIT_DN  = 8'b0000_1000,
    DONE     = 8'b0001_0000,
    WAIT_LOW = 8'b0010_0000
  } state_t;

  localparam logic [9:0] PAGE_QW  = 10'd512;
  localparam logic [2:0] MPS_128  = 3'd0;
  localparam logic [2:0] MPS_256  = 3'd1;
  localparam logic [2:0] MPS_512  = 3'd2;
  localparam logic [2:0] MPS_1024 = 3'd3;
  localparam logic [2:0] MPS_2048 = 3'd4;
  localparam logic [2:0] MPS_4096 = 3'd5;

  // Reserved encodings fall back to the smallest payload
  function automatic logic [9:0] pld_qw(input logic [2:0] mps);
    pld_qw = (mps <= MPS_4096) ? (10'd16 << mps) : 10'd16;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lbuf_bst_size.sv
// ============================================================================
// lbuf_bst_size - burst size = min(remaining qwords, max payload, 4KB residue)
// Revision: 1.0
// ============================================================================
`default_nettype none

module lbuf_bst_size
  import lbuf_pkg::*;
(
  input  logic [28:0] rem_qw,
  input  logic [2:0]  max_pld,
  input  logic [8:0]  page_off,
  output logic [9:0]  size
);

  logic [9:0] rem_clip;
  logic [9:0] pld;
  logic [9:0] page_res;
  logic [9:0] min_rp;

  always_comb begin
    rem_clip = (rem_qw >= 29'(PAGE_QW)) ? PAGE_QW : rem_qw[9:0];
    pld      = pld_qw(max_pld);
    page_res = PAGE_QW - {1'b0, page_off};
    min_rp   = (rem_clip < pld) ? rem_clip : pld;
    size     = (min_rp < page_res) ? min_rp : page_res;
  end

endmodule

`default_nettype wire

// File: rtl/lbuf_burst_gen.sv
// ============================================================================
// lbuf_burst_gen - splits a granted host buffer into PCIe write bursts.
// Optional partial-flush timer: define LBUF_FLUSH_TMR_EN.  Revision: 1.0
// ============================================================================
`default_nettype none

module lbuf_burst_gen
  import lbuf_pkg::*;
#(
  parameter int AVAIL_W = 11,
  parameter int TMO_CYC = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [63:0]        lbuf_addr,
  input  logic [31:0]        lbuf_len,
  input  logic               lbuf_en,
  input  logic               lbuf64b,
  output logic               lbuf_dn,
  input  logic [2:0]         max_pld,
  input  logic [AVAIL_W-1:0] avail_qw,
  output logic               bst_req,
  input  logic               bst_ack,
  output logic [63:0]        bst_addr,
  output logic [9:0]         bst_qw,
  output logic               bst_64b,
  input  logic               bst_done
);

  localparam int CW = (AVAIL_W > 10) ? AVAIL_W : 10;

  state_t        state, state_nxt;
  logic [63:0]   cur_addr;
  logic [28:0]   rem_qw;
  logic [9:0]    size_q;
  logic [9:0]    size_calc;
  logic          req_hold;
  logic          flush_load;
  logic [CW-1:0] avail_x;
  logic [CW-1:0] size_x;
  logic          unused_bits;

  assign avail_x  = CW'(avail_qw);
  assign size_x   = CW'(size_q);
  assign bst_addr = cur_addr;
  assign bst_qw   = size_q;

  // Once raised, req_hold keeps the request up even if avail_qw falls back
  assign bst_req = (state == REQ) && (req_hold || (avail_x >= size_x));

  lbuf_bst_size u_size (
    .rem_qw   (rem_qw),
    .max_pld  (max_pld),
    .page_off (cur_addr[11:3]),
    .size     (size_calc)
  );

`ifdef LBUF_FLUSH_TMR_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] tmo_cnt;
  logic          starve;

  assign starve     = (state == REQ) && !bst_req && (avail_x != '0) && (avail_x < size_x);
  assign flush_load = starve && (tmo_cnt == TW'(TMO_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || (state != REQ) || bst_ack || flush_load) tmo_cnt <= '0;
    else if (starve)                                    tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign unused_bits = ^{lbuf_len[2:0]};
`else
  assign flush_load  = 1'b0;
  assign unused_bits = ^{lbuf_len[2:0], (TMO_CYC != 0)};
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (lbuf_en) state_nxt = (lbuf_len[31:3] == 29'd0) ? DONE : CALC;
      CALC:     state_nxt = REQ;
      REQ:      if (bst_req && bst_ack) state_nxt = WAIT_DN;
      WAIT_DN:  if (bst_done) state_nxt = (rem_qw == 29'd0) ? DONE : CALC;
      DONE:     state_nxt = WAIT_LOW;
      WAIT_LOW: if (!lbuf_en) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr <= '0;
      rem_qw   <= '0;
      size_q   <= '0;
      bst_64b  <= 1'b0;
      lbuf_dn  <= 1'b0;
      req_hold <= 1'b0;
    end else begin
      lbuf_dn  <= (state == DONE);
      req_hold <= bst_req && !bst_ack;
      case (state)
        IDLE: if (lbuf_en) begin
          cur_addr <= lbuf_addr;
          rem_qw   <= lbuf_len[31:3];
          bst_64b  <= lbuf64b;
        end
        CALC: size_q <= size_calc;
        REQ: begin
          if (bst_req && bst_ack) begin
            cur_addr <= cur_addr + {51'd0, size_q, 3'd0};
            rem_qw   <= rem_qw - {19'd0, size_q};
          end else if (flush_load) begin
            size_q <= 10'(avail_qw);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lbuf_burst_gen.sv
// Directed bench for lbuf_burst_gen: table of whole-buffer transfers plus
// hand sequences for data starvation, ack back-pressure and mid-buffer reset.
`default_nettype none

module tb_lbuf_burst_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] lbuf_addr;
  logic [31:0] lbuf_len;
  logic        lbuf_en;
  logic        lbuf64b;
  logic        lbuf_dn;
  logic [2:0]  max_pld;
  logic [10:0] avail_qw;
  logic        bst_req;
  logic        bst_ack;
  logic [63:0] bst_addr;
  logic [9:0]  bst_qw;
  logic        bst_64b;
  logic        bst_done;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lbuf_burst_gen dut (
    .clk(clk), .rst(rst),
    .lbuf_addr(lbuf_addr), .lbuf_len(lbuf_len), .lbuf_en(lbuf_en), .lbuf64b(lbuf64b),
    .lbuf_dn(lbuf_dn), .max_pld(max_pld), .avail_qw(avail_qw),
    .bst_req(bst_req), .bst_ack(bst_ack), .bst_addr(bst_addr), .bst_qw(bst_qw),
    .bst_64b(bst_64b), .bst_done(bst_done)
  );

  typedef struct {
    logic [63:0] addr;
    logic [31:0] len;
    logic [2:0]  mp;
    logic        is64;
    int          nb;
    logic [63:0] fa;
    int          fq;
    logic [63:0] la;
    int          lq;
    int          sum;
    int          hold;
  } vec_t;

  vec_t tbl [8];

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run_buf(input vec_t v);
    int          nb  = 0;
    int          sum = 0;
    int          cyc = 0;
    int          pld;
    int          fq  = 0;
    int          lq  = 0;
    logic [63:0] fa  = '0;
    logic [63:0] la  = '0;
    logic        dn_seen = 1'b0;
    pld = (v.mp <= 3'd5) ? (16 << v.mp) : 16;
    lbuf_addr = v.addr; lbuf_len = v.len; max_pld = v.mp; lbuf64b = v.is64;
    avail_qw  = 11'd1024;
    lbuf_en   = 1'b1;
    step();
    chk("bst_64b_latch", bst_64b, v.is64);
    if (v.nb > 0) chk("first_req_early", bst_req, 0);
    lbuf_addr = 64'hDEAD_BEEF_0000_0000;
    lbuf_len  = 32'h0000_0100;
    step();
    if (v.nb > 0) chk("first_req_lat2", bst_req, 1);
    else          chk("dn_len0_lat2", lbuf_dn, 1);
    while (!dn_seen && cyc < 3000) begin
      if (lbuf_dn) begin
        dn_seen = 1'b1;
      end else if (bst_req) begin
        if (nb == 0) begin fa = bst_addr; fq = int'(bst_qw); end
        la = bst_addr; lq = int'(bst_qw);
        nb++; sum += int'(bst_qw);
        chk("qw_le_pld", (int'(bst_qw) <= pld), 1);
        chk("no_4k_cross", ((int'(bst_addr[11:0]) + int'(bst_qw) * 8) <= 4096), 1);
        bst_ack = 1'b1; step(); bst_ack = 1'b0;
        chk("req_drop_after_ack", bst_req, 0);
        repeat (2) step();
        bst_done = 1'b1; step(); bst_done = 1'b0;
        chk("dn_not_early", lbuf_dn, 0);
        step();
        cyc += 6;
        if (nb == v.nb) chk("dn_after_last_done", lbuf_dn, 1);
        else            chk("done_to_req_lat2", bst_req, 1);
      end else begin
        step();
        cyc++;
      end
    end
    chk("buffer_timeout", dn_seen, 1);
    for (int i = 0; i < v.hold; i++) begin
      step();
      chk("no_restart_en_high", {bst_req, lbuf_dn}, 0);
    end
    lbuf_en = 1'b0;
    step(); step();
    chk("burst_count", nb, v.nb);
    chk("total_qw", sum, v.sum);
    if (v.nb > 0) begin
      chk("first_addr", fa, v.fa);
      chk("first_qw", fq, v.fq);
      chk("last_addr", la, v.la);
      chk("last_qw", lq, v.lq);
    end
  endtask

  initial begin
    logic        any_req;
    logic        stable;
    vec_t        fresh;

    //            addr                    len    mp    64b  nb  first addr          fq  last addr            lq  sum  hold
    tbl[0] = '{64'h0000_1000,           8192, 3'd1, 1'b0, 32, 64'h1000,            32, 64'h2F00,           32, 1024, 1};
    tbl[1] = '{64'h0000_0F80,            512, 3'd5, 1'b0,  2, 64'h0F80,            16, 64'h1000,           48,   64, 1};
    tbl[2] = '{64'h1_0000_0000,            0, 3'd5, 1'b1,  0, 64'h0,                0, 64'h0,               0,    0, 10};
    tbl[3] = '{64'h0000_0FF8,             64, 3'd5, 1'b0,  2, 64'h0FF8,             1, 64'h1000,            7,    8, 1};
    tbl[4] = '{64'h0000_0000,              8, 3'd7, 1'b0,  1, 64'h0,                1, 64'h0,               1,    1, 1};
    tbl[5] = '{64'h0000_2000,           4800, 3'd0, 1'b0, 38, 64'h2000,            16, 64'h3280,            8,  600, 1};
    tbl[6] = '{64'hFFFF_FFFF_FFFF_FF00,  512, 3'd5, 1'b1,  2, 64'hFFFF_FFFF_FFFF_FF00, 32, 64'h0,           32,   64, 1};
    tbl[7] = '{64'h0000_0100,           4096, 3'd2, 1'b0,  9, 64'h0100,            64, 64'h1000,           32,  512, 1};

    rst = 1'b1; lbuf_addr = '0; lbuf_len = '0; lbuf_en = 1'b0; lbuf64b = 1'b0;
    max_pld = '0; avail_qw = '0; bst_ack = 1'b0; bst_done = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_lbuf_dn", lbuf_dn, 0);
    chk("rst_bst_req", bst_req, 0);
    chk("rst_bst_64b", bst_64b, 0);
    chk("rst_bst_addr", bst_addr, 0);
    chk("rst_bst_qw", bst_qw, 0);

    for (int i = 0; i < 8; i++) run_buf(tbl[i]);

    // Starvation: 16-qw bursts with only 5 qwords committed
    lbuf_addr = 64'h4000; lbuf_len = 32'd1024; max_pld = 3'd0; lbuf64b = 1'b1;
    avail_qw = 11'd5; lbuf_en = 1'b1;
    step(); step();
    any_req = 1'b0;
    for (int i = 0; i < 100; i++) begin
      any_req |= bst_req;
      step();
    end
    chk("starved_no_req", any_req, 0);
    avail_qw = 11'd16;
    step();
    chk("starve_release_req", bst_req, 1);
    chk("starve_release_qw", bst_qw, 16);
    chk("starve_release_addr", bst_addr, 64'h4000);

    // Back-pressure: request must stay frozen while avail toggles
    for (int i = 0; i < 20; i++) begin
      avail_qw = (i % 2 == 0) ? 11'd0 : 11'd1024;
      step();
      stable = bst_req && (bst_addr == 64'h4000) && (bst_qw == 10'd16);
      chk("req_stable_no_ack", stable, 1);
    end
    avail_qw = 11'd1024;
    bst_ack = 1'b1; step(); bst_ack = 1'b0;
    chk("wait_dn_req_low", bst_req, 0);

    // Reset inside WAIT_DN abandons the buffer
    lbuf_en = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    step();
    chk("midrst_bst_req", bst_req, 0);
    chk("midrst_bst_64b", bst_64b, 0);
    chk("midrst_bst_addr", bst_addr, 0);
    bst_done = 1'b1; step(); bst_done = 1'b0;
    any_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      any_req |= lbuf_dn | bst_req;
      step();
    end
    chk("midrst_no_dn", any_req, 0);

    fresh = '{64'h0000_8000, 64, 3'd5, 1'b0, 1, 64'h8000, 8, 64'h8000, 8, 8, 1};
    run_buf(fresh);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lbuf_burst_gen.md
Name: lbuf_burst_gen

Overview:
- Sits directly downstream of the lbuf dispenser and consumes its lbuf_addr/lbuf_len/lbuf_en/lbuf64b handshake.
- Cuts the granted host buffer into PCIe memory-write bursts. Each burst respects max payload size, 4KB boundaries and the data committed in the rx packet buffer.
- Hands each burst to the TLP sender and returns lbuf_dn once the whole buffer has been written.

Parameters:
- AVAIL_W, 11: width of the committed-qword count from the rx buffer.
- TMO_CYC, 256: idle cycles before a partial flush (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- lbuf_addr  in  64  host buffer byte address, qword aligned
- lbuf_len  in  32  buffer length in bytes, multiple of 8
- lbuf_en  in  1  buffer granted
- lbuf64b  in  1  address needs 64-bit TLP
- lbuf_dn  out  1  one-cycle pulse, buffer fully written
- max_pld  in  3  0..5 = 128..4096 B; 6,7 treated as 128 B
- avail_qw  in  AVAIL_W  qwords committed in rx buffer
- bst_req  out  1  burst request
- bst_ack  in  1  sender accepted burst
- bst_addr  out  64  burst host byte address
- bst_qw  out  10  burst length in qwords, 1..512
- bst_64b  out  1  copy of latched lbuf64b
- bst_done  in  1  sender finished current burst

Behaviour:
- Clocking and reset: single clock, synchronous active-high reset, as decided. Reset puts FSM in IDLE; lbuf_dn, bst_req, bst_64b = 0; bst_addr, bst_qw = 0. A reset mid-operation abandons the buffer with no lbuf_dn.
- Internal registers: cur_addr[63:0], rem_qw[28:0] = lbuf_len[31:3], pld_qw = 16 << max_pld.
- IDLE: on lbuf_en=1, latch cur_addr, rem_qw and bst_64b. If rem_qw==0, go to DONE; otherwise go to CALC.
- CALC (1 cycle): size = min(rem_qw, pld_qw, 512 - cur_addr[11:3]); register it. Go to REQ. max_pld is sampled here only.
- REQ:
  - Assert bst_req, with bst_addr=cur_addr and bst_qw=size, only while avail_qw >= size. Without the flush feature the block waits indefinitely.
  - bst_req/addr/qw stay stable until bst_ack. Once asserted, bst_req is never withdrawn, even if avail_qw drops.
  - On bst_ack: drop bst_req; cur_addr += size*8 (64-bit wrap permitted); rem_qw -= size; go to WAIT_DN.
- WAIT_DN: on bst_done, go to DONE if rem_qw==0, else CALC. A bst_done arriving in the same cycle as bst_ack is ignored.
- DONE: pulse lbuf_dn for 1 cycle, then go to WAIT_LOW.
- WAIT_LOW: wait for lbuf_en=0 (the upstream stage drops it the cycle after lbuf_dn), then go to IDLE. This prevents re-accepting a stale grant.
- Latency: lbuf_en high to first bst_req = 2 cycles when data is available. bst_done to next bst_req = 2 cycles.
- 4KB rule: no burst crosses an address[11:0] wrap. An address ending 0xFF8 yields a 1-qword burst.
- Inputs lbuf_addr/lbuf_len are ignored outside IDLE.

Optional Feature:
- Macro LBUF_FLUSH_TMR_EN.
- Defined:
  - A counter increments each REQ cycle with 0 < avail_qw < size and no bst_req.
  - At TMO_CYC the size register is reloaded with avail_qw, and bst_req is issued for that partial burst.
  - The counter clears on any bst_ack or on leaving REQ.
- Undefined: no counter; REQ waits for avail_qw >= size.

Decomposition:
- Shared package lbuf_pkg:
  - FSM state encodings (IDLE, CALC, REQ, WAIT_DN, DONE, WAIT_LOW), one-hot 8-bit style.
  - max_pld decode constants and 4KB page qword constant 512.
- One natural sub-module, lbuf_bst_size: combinational min of rem_qw / pld_qw / page residue, registered by the parent.

Test Plan:
- addr=0x0000_1000, len=8192, max_pld=1 (256B), avail=1024 -> 32 bursts of 32 qw at 0x1000, 0x1100, ... 0x2F00; lbuf_dn one pulse after 32nd bst_done.
- addr=0x0000_0F80, len=512, max_pld=5 -> bursts 16 qw @0xF80 then 48 qw @0x1000 (4KB split), lbuf_dn.
- addr=0x1_0000_0000, len=0 -> bst_64b=1, no bst_req, lbuf_dn 2 cycles after lbuf_en; no restart while lbuf_en held high.
- len=1024, max_pld=0, avail=5 rising to 16 after 100 cycles -> bst_req waits, asserts with bst_qw=16 once avail=16; with LBUF_FLUSH_TMR_EN and TMO_CYC=32 -> 5-qw burst after 32 cycles.
- Reset asserted in WAIT_DN mid-buffer -> bst_req=0, lbuf_dn never pulses; new lbuf_en after reset starts from fresh addr.
- bst_ack held off 20 cycles while avail_qw toggles -> bst_req, bst_addr, bst_qw stable throughout.
